// File: rtl/axis_random_throttle.sv
// Valid/ready register slice that injects LFSR-driven gaps in s_tready.
// The stall pattern depends only on SEED, so it repeats after every reset.
module axis_random_throttle #(
    parameter int          W              = 16,
    parameter logic [31:0] SEED           = 32'hACE1_2345,
    parameter int          STALL_LEN_LOG2 = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [7:0]   stall_thresh,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tlast,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tlast,
    output logic [31:0]  beat_count,
    output logic [31:0]  stall_cycles
);

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced.
    localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [8:0]  LEN_MASK  = 9'((1 << STALL_LEN_LOG2) - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [8:0]     r_cnt;
    logic [8:0]     w_cnt_next;
    logic [31:0]    r_lfsr;
    logic [31:0]    w_lfsr_next;
    logic           r_m_tvalid;
    logic [W-1:0]   r_m_tdata;
    logic           r_m_tlast;
    logic [31:0]    r_beat_count;
    logic [31:0]    r_stall_cycles;

    logic           w_up_accept;
    logic           w_dn_accept;
    logic           w_stall_start;
    logic [8:0]     w_stall_len;

    assign w_lfsr_next   = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);

    assign s_tready      = (!r_m_tvalid || m_tready) && (r_state == ST_RUN);
    assign w_up_accept   = s_tvalid && s_tready;
    assign w_dn_accept   = r_m_tvalid && m_tready;
    assign w_stall_start = w_up_accept && enable && (r_lfsr[7:0] < stall_thresh);
    assign w_stall_len   = ({1'b0, r_lfsr[15:8]} & LEN_MASK) + 9'd1;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (w_stall_start) begin
                    w_state_next = ST_STALL;
                    w_cnt_next   = w_stall_len;
                end
            end
            ST_STALL: begin
                w_cnt_next = r_cnt - 9'd1;
                if (!enable || (r_cnt == 9'd1)) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 9'd0;
            r_lfsr  <= LFSR_INIT;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_lfsr  <= w_lfsr_next;
        end
    end

    // A simultaneous downstream accept is absorbed by the reload, so the
    // slice streams one beat per cycle while m_tready stays high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
        end else if (w_up_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= s_tdata;
            r_m_tlast  <= s_tlast;
        end else if (w_dn_accept) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_count   <= 32'd0;
            r_stall_cycles <= 32'd0;
        end else begin
            if (w_up_accept) begin
                r_beat_count <= r_beat_count + 32'd1;
            end
            if (r_state == ST_STALL) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign m_tvalid     = r_m_tvalid;
    assign m_tdata      = r_m_tdata;
    assign m_tlast      = r_m_tlast;
    assign beat_count   = r_beat_count;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_axis_random_throttle.sv
// Bench for axis_random_throttle: two instances (stall length 1 and up to 256)
// checked every cycle against a stall-window / scoreboard reference model.
module tb_axis_random_throttle;

    localparam int          W        = 16;
    localparam int          SB_DEPTH = 64;
    localparam logic [31:0] SEED0    = 32'h0;
    localparam logic [31:0] SEED1    = 32'hACE1_2345;

    logic clk = 1'b0;
    logic reset;

    logic         enable       [2];
    logic [7:0]   stall_thresh [2];
    logic         s_tvalid     [2];
    logic         s_tready     [2];
    logic [W-1:0] s_tdata      [2];
    logic         s_tlast      [2];
    logic         m_tvalid     [2];
    logic         m_tready     [2];
    logic [W-1:0] m_tdata      [2];
    logic         m_tlast      [2];
    logic [31:0]  beat_count   [2];
    logic [31:0]  stall_cycles [2];

    always #5 clk = ~clk;

    axis_random_throttle #(.W(W), .SEED(SEED0), .STALL_LEN_LOG2(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable[0]), .stall_thresh(stall_thresh[0]),
        .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]), .s_tdata(s_tdata[0]), .s_tlast(s_tlast[0]),
        .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .m_tdata(m_tdata[0]), .m_tlast(m_tlast[0]),
        .beat_count(beat_count[0]), .stall_cycles(stall_cycles[0])
    );

    axis_random_throttle #(.W(W), .SEED(SEED1), .STALL_LEN_LOG2(8)) dut1 (
        .clk(clk), .reset(reset), .enable(enable[1]), .stall_thresh(stall_thresh[1]),
        .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]), .s_tdata(s_tdata[1]), .s_tlast(s_tlast[1]),
        .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .m_tdata(m_tdata[1]), .m_tlast(m_tlast[1]),
        .beat_count(beat_count[1]), .stall_cycles(stall_cycles[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: a stall is a window of cycle numbers, the register is a scoreboard.
    logic [31:0] model_seed [2] = '{32'h1, SEED1};
    logic [7:0]  len_mask   [2] = '{8'h00, 8'hFF};
    logic [31:0] m_lfsr      [2];
    int          m_stall_end [2];
    int          m_beats     [2];
    int          m_stalls    [2];
    int          rx_count    [2];
    logic [W:0]  sb          [2][SB_DEPTH];
    logic [5:0]  sb_wr       [2];
    logic [5:0]  sb_rd       [2];

    logic         obs_rdy    [2];
    logic         obs_acc    [2];
    logic         obs_dn     [2];
    logic         obs_mvalid [2];
    logic [W-1:0] obs_mdata  [2];
    logic         obs_mlast  [2];

    logic         pend      [2];
    logic [W:0]   pend_beat [2];
    int           tx_done   [2];

    logic [31:0]  pat1;
    logic [31:0]  pat2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic model_cycle(input bit k);
        logic       stalled;
        logic       full;
        logic       exp_rdy;
        logic       up;
        logic       dn;
        logic [W:0] head;
        int         len;
        string      tg;
        tg = k ? "i1" : "i0";
        obs_rdy[k]    = s_tready[k];
        obs_acc[k]    = s_tvalid[k] && s_tready[k];
        obs_dn[k]     = m_tvalid[k] && m_tready[k];
        obs_mvalid[k] = m_tvalid[k];
        obs_mdata[k]  = m_tdata[k];
        obs_mlast[k]  = m_tlast[k];
        if (reset) begin
            m_lfsr[k]      = model_seed[k];
            m_stall_end[k] = -1;
            m_beats[k]     = 0;
            m_stalls[k]    = 0;
            rx_count[k]    = 0;
            sb_wr[k]       = '0;
            sb_rd[k]       = '0;
            obs_acc[k]     = 1'b0;
            obs_dn[k]      = 1'b0;
            return;
        end
        if (obs_dn[k]) rx_count[k]++;
        stalled = (cyc <= m_stall_end[k]);
        full    = (sb_wr[k] != sb_rd[k]);
        exp_rdy = (!full || m_tready[k]) && !stalled;
        head    = sb[k][sb_rd[k]];
        check({tg, ".s_tready"}, 32'(s_tready[k]), 32'(exp_rdy));
        check({tg, ".m_tvalid"}, 32'(m_tvalid[k]), 32'(full));
        if (full) begin
            check({tg, ".m_tdata"}, 32'(m_tdata[k]), 32'(head[W-1:0]));
            check({tg, ".m_tlast"}, 32'(m_tlast[k]), 32'(head[W]));
        end
        check({tg, ".beat_count"}, beat_count[k], m_beats[k]);
        check({tg, ".stall_cycles"}, stall_cycles[k], m_stalls[k]);
        up = s_tvalid[k] && exp_rdy;
        dn = full && m_tready[k];
        if (stalled) m_stalls[k]++;
        if (stalled && !enable[k]) m_stall_end[k] = cyc;
        if (dn) sb_rd[k] = sb_rd[k] + 6'd1;
        if (up) begin
            sb[k][sb_wr[k]] = {s_tlast[k], s_tdata[k]};
            sb_wr[k] = sb_wr[k] + 6'd1;
            m_beats[k]++;
            if (enable[k] && (m_lfsr[k][7:0] < stall_thresh[k])) begin
                len = 32'(m_lfsr[k][15:8] & len_mask[k]) + 1;
                m_stall_end[k] = cyc + len;
            end
        end
        m_lfsr[k] = lfsr_step(m_lfsr[k]);
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle(1'b0);
        model_cycle(1'b1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit k);
        s_tvalid[k] = 1'b0;
        s_tdata[k]  = '0;
        s_tlast[k]  = 1'b0;
        m_tready[k] = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input bit k, input string tag);
        check({tag, ".m_tvalid"}, 32'(m_tvalid[k]), 32'd0);
        check({tag, ".m_tdata"}, 32'(m_tdata[k]), 32'd0);
        check({tag, ".m_tlast"}, 32'(m_tlast[k]), 32'd0);
        check({tag, ".beat_count"}, beat_count[k], 32'd0);
        check({tag, ".stall_cycles"}, stall_cycles[k], 32'd0);
        check({tag, ".s_tready"}, 32'(s_tready[k]), 32'd1);
    endtask

    task automatic capture(output logic [31:0] pat);
        logic [W-1:0] d;
        d = '0;
        pat = '0;
        enable[0] = 1'b1;
        stall_thresh[0] = 8'h80;
        m_tready[0] = 1'b1;
        s_tvalid[0] = 1'b1;
        s_tlast[0] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            s_tdata[0] = d;
            tick();
            pat[i[4:0]] = obs_rdy[0];
            if (obs_acc[0]) d = d + 1'b1;
        end
        idle(1'b0);
    endtask

    // Idle cycles needed before the next cycle whose LFSR satisfies the scenario.
    // mode 0: no 0xFF low byte on 100 accepts spaced two cycles apart.
    // mode 1: one accept that triggers a stall of at least 10 cycles.
    task automatic find_offset(input bit k, input int mode, output int off);
        logic [31:0] base;
        logic [31:0] x;
        logic        ok;
        off  = -1;
        base = m_lfsr[k];
        for (int o = 0; o < 4000 && off < 0; o++) begin
            x  = base;
            ok = 1'b1;
            if (mode == 0) begin
                for (int j = 0; j < 100; j++) begin
                    if (x[7:0] == 8'hFF) ok = 1'b0;
                    x = lfsr_step(lfsr_step(x));
                end
            end else begin
                ok = (x[7:0] != 8'hFF) && (x[15:8] >= 8'd9);
            end
            if (ok) off = o;
            base = lfsr_step(base);
        end
        check("seed_search", 32'(off >= 0), 32'd1);
        if (off < 0) off = 0;
    endtask

    task automatic run_traffic(input int n0, input int n1, input int vpct, input int rpct,
                               input int budget, input string tag);
        int          cycles;
        int          target;
        logic [31:0] r32;
        cycles = 0;
        for (int k = 0; k < 2; k++) begin
            tx_done[k[0]] = 0;
            pend[k[0]]    = 1'b0;
        end
        while ((tx_done[0] < n0 || tx_done[1] < n1) && cycles < budget) begin
            for (int k = 0; k < 2; k++) begin
                target = k[0] ? n1 : n0;
                if (tx_done[k[0]] < target) begin
                    if (!pend[k[0]] && ($urandom_range(99) < vpct)) begin
                        r32 = $urandom;
                        pend[k[0]] = 1'b1;
                        pend_beat[k[0]] = r32[W:0];
                    end
                    s_tvalid[k[0]] = pend[k[0]];
                    {s_tlast[k[0]], s_tdata[k[0]]} = pend_beat[k[0]];
                    m_tready[k[0]] = ($urandom_range(99) < rpct);
                end else begin
                    idle(k[0]);
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                if (obs_acc[k[0]]) begin
                    pend[k[0]] = 1'b0;
                    tx_done[k[0]]++;
                end
            end
            cycles++;
        end
        check({tag, ".sent0"}, tx_done[0], n0);
        check({tag, ".sent1"}, tx_done[1], n1);
        idle(1'b0);
        idle(1'b1);
    endtask

    initial begin
        int off;
        int last_cyc;
        int acc;

        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            idle(k[0]);
            enable[k[0]]       = 1'b0;
            stall_thresh[k[0]] = 8'h00;
            pend_beat[k[0]]    = '0;
        end

        // Power-up reset, then record the reference stall pattern.
        do_reset();
        check_reset_state(1'b0, "por0");
        check_reset_state(1'b1, "por1");
        capture(pat1);

        // No stalls: 100 back-to-back beats, last one out at cycle 101.
        do_reset();
        enable[0] = 1'b1;
        stall_thresh[0] = 8'h00;
        m_tready[0] = 1'b1;
        last_cyc = -1;
        for (int i = 1; i <= 105; i++) begin
            s_tvalid[0] = (i <= 100);
            s_tdata[0]  = 16'(i - 1);
            s_tlast[0]  = (i == 100);
            tick();
            if (obs_mvalid[0] && obs_mdata[0] == 16'd99) last_cyc = i;
        end
        idle(1'b0);
        check("nostall.last_cycle", last_cyc, 101);
        check("nostall.beat_count", beat_count[0], 32'd100);
        check("nostall.stall_cycles", stall_cycles[0], 32'd0);

        // Stall after every beat: ready alternates 1,0 for 200 cycles.
        do_reset();
        enable[0] = 1'b1;
        stall_thresh[0] = 8'hFF;
        find_offset(1'b0, 0, off);
        repeat (off) tick();
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            s_tvalid[0] = (acc < 100);
            s_tdata[0]  = 16'(acc);
            tick();
            check("alt.s_tready", 32'(obs_rdy[0]), 32'(i % 2 == 0));
            if (obs_acc[0]) acc++;
        end
        idle(1'b0);
        check("alt.beats", acc, 100);
        check("alt.beat_count", beat_count[0], 32'd100);
        check("alt.stall_cycles", stall_cycles[0], 32'd100);

        // Held output: full register with m_tready low for 20 cycles.
        stall_thresh[0] = 8'h00;
        m_tready[0] = 1'b0;
        s_tvalid[0] = 1'b1;
        s_tdata[0]  = 16'hA5A5;
        s_tlast[0]  = 1'b1;
        tick();
        check("hold.first_accept", 32'(obs_acc[0]), 32'd1);
        s_tdata[0] = 16'h1234;
        s_tlast[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold.m_tvalid", 32'(obs_mvalid[0]), 32'd1);
            check("hold.m_tdata", 32'(obs_mdata[0]), 32'hA5A5);
            check("hold.m_tlast", 32'(obs_mlast[0]), 32'd1);
            check("hold.s_tready", 32'(obs_rdy[0]), 32'd0);
        end
        m_tready[0] = 1'b1;
        tick();
        check("hold.release_data", 32'(obs_mdata[0]), 32'hA5A5);
        check("hold.next_accept", 32'(obs_acc[0]), 32'd1);
        s_tvalid[0] = 1'b0;
        tick();
        check("hold.next_data", 32'(obs_mdata[0]), 32'h1234);
        check("hold.next_valid", 32'(obs_mvalid[0]), 32'd1);
        idle(1'b0);

        // Enable dropped during the fourth cycle of a long stall.
        do_reset();
        enable[1] = 1'b1;
        stall_thresh[1] = 8'hFF;
        find_offset(1'b1, 1, off);
        repeat (off) tick();
        s_tvalid[1] = 1'b1;
        s_tdata[1]  = 16'h0DD0;
        tick();
        check("edrop.trigger_accept", 32'(obs_acc[1]), 32'd1);
        s_tvalid[1] = 1'b0;
        repeat (3) tick();
        check("edrop.stalled", 32'(s_tready[1]), 32'd0);
        enable[1] = 1'b0;
        tick();
        check("edrop.s_tready", 32'(s_tready[1]), 32'd1);
        check("edrop.stall_cycles", stall_cycles[1], 32'd4);
        repeat (3) tick();
        check("edrop.stall_cycles_after", stall_cycles[1], 32'd4);

        // Reset while stalled with a full register; pattern must restart.
        enable[0] = 1'b1;
        stall_thresh[0] = 8'hFF;
        m_tready[0] = 1'b0;
        find_offset(1'b0, 1'b0 == 1'b1 ? 1 : 2, off);
        repeat (off) tick();
        s_tvalid[0] = 1'b1;
        s_tdata[0]  = 16'hBEEF;
        tick();
        s_tvalid[0] = 1'b0;
        check("rst.pre_s_tready", 32'(s_tready[0]), 32'd0);
        check("rst.pre_m_tvalid", 32'(m_tvalid[0]), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state(1'b0, "rst");
        capture(pat2);
        check("rst.pattern", pat2, pat1);

        // Random traffic on both instances.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            enable[k[0]] = 1'b1;
            stall_thresh[k[0]] = 8'd64;
        end
        run_traffic(10000, 800, 50, 50, 90000, "rand");
        repeat (4) tick();
        check("rand.beat_count0", beat_count[0], 32'd10000);
        check("rand.beat_count1", beat_count[1], 32'd800);
        check("rand.stall_cycles0", stall_cycles[0], m_stalls[0]);
        check("rand.stall_cycles1", stall_cycles[1], m_stalls[1]);
        check("rand.delivered0", rx_count[0], 10000);
        check("rand.delivered1", rx_count[1], 800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_random_throttle.md
# axis_random_throttle

Synthesizable valid/ready stream stage that applies pseudo-random backpressure on its upstream side and registers the data onto its downstream side. It is the consumer-side counterpart of the bench's random producer delay: the source injects gaps in `valid`, and this block injects gaps in `ready`. Benches instantiate it between a DUT and a sink to stress handshake corner cases. The same stall pattern repeats for the same seed.

## Interface
- `W`, 16, data width in bits.
- `SEED`, 32'hACE1_2345, LFSR reset value. A value of 0 is replaced by 32'h1.
- `STALL_LEN_LOG2`, 3, stall length is 1..2^STALL_LEN_LOG2 cycles. Legal range 0..8.

- `clk`  in  1  clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  stall injection enable. When low, the block behaves as a plain register slice.
- `stall_thresh`  in  8  stall probability; a stall starts when `lfsr[7:0] < stall_thresh`.
- `s_tvalid`  in  1  upstream valid.
- `s_tready`  out  1  upstream ready.
- `s_tdata`  in  W  upstream data.
- `s_tlast`  in  1  upstream last.
- `m_tvalid`  out  1  downstream valid.
- `m_tready`  in  1  downstream ready.
- `m_tdata`  out  W  downstream data.
- `m_tlast`  out  1  downstream last.
- `beat_count`  out  32  number of upstream beats accepted.
- `stall_cycles`  out  32  number of cycles spent in STALL.

## Operation
- **LFSR.** 32-bit Galois LFSR.
  - Update every cycle: `lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 0)`.
  - Runs regardless of `enable` or traffic.
- **Output register.** One entry holding `m_tvalid`, `m_tdata` and `m_tlast`.
  - `full = m_tvalid`.
  - `s_tready = (!full || m_tready) && (state == RUN)`. This is combinational from registered state and `m_tready`.
  - An upstream accept (`s_tvalid && s_tready`) loads the register and sets `m_tvalid`.
  - A downstream accept with no simultaneous upstream accept clears `m_tvalid`.
- **State machine.** States are RUN and STALL.
  - RUN to STALL: an upstream accept this cycle, `enable == 1`, and `lfsr[7:0] < stall_thresh`. The comparison is unsigned, 8 bits.
    - On entry, load `cnt <= (lfsr[15:8] & (2^STALL_LEN_LOG2 - 1)) + 1`.
    - `cnt` is 9 bits.
  - In STALL: decrement `cnt` each cycle. Return to RUN on the cycle `cnt == 1`.
  - `enable` low in STALL returns to RUN on the next edge, abandoning the stall.
- **Stall rules.**
  - A stall affects only `s_tready`.
  - A held `m_tvalid` is never withdrawn, and data is never dropped or duplicated.
  - `m_tdata` and `m_tlast` stay stable while `m_tvalid && !m_tready`.
- **Counters.**
  - `beat_count` increments on each upstream accept.
  - `stall_cycles` increments on each cycle in STALL.
  - Both wrap at 2^32.

## Timing
- **Reset values.** `m_tvalid` 0, `m_tdata` 0, `m_tlast` 0, state RUN, `cnt` 0, `lfsr` SEED, `beat_count` 0, `stall_cycles` 0.
  - `s_tready` reads 1 during reset because the register is empty and the state is RUN.
  - Upstream accepts during reset are not captured.
- **Latency.** Upstream beat to `m_tvalid` is 1 cycle.
- **Throughput.** With `enable = 0` and `m_tready = 1`, one beat per cycle.
- **Stall length.** After a triggering beat at cycle t, `s_tready` is low for exactly `cnt` cycles, t+1..t+cnt, and high again at t+cnt+1 if the register allows.
- **Full register.** Simultaneous upstream and downstream accept keeps `m_tvalid` high and replaces the data in the same edge.
- **Reset mid-stall.** The state returns to RUN and the register is emptied; the next cycle proceeds as after power-up.
- **Register change.** `stall_thresh` is sampled only in RUN on the accept cycle; changing it during STALL has no effect on the current stall.

## Test plan
- **No stalls.** `enable = 1`, `stall_thresh = 0`, `m_tready = 1`, 100 back-to-back beats with data 0..99. Required: `m_tdata` 0..99 in order, last beat at cycle 101, `stall_cycles = 0`, `beat_count = 100`.
- **Stall after every beat.** `stall_thresh = 255` replaced by a forced-compare value via `STALL_LEN_LOG2 = 0` with `stall_thresh = 8'hFF`, and `SEED` chosen so `lfsr[7:0] != 8'hFF` on the first 100 accepts; the bench checks this against its LFSR model. Required: `s_tready` alternates 1,0. 100 beats take 200 cycles and `stall_cycles = 100`.
- **Held output.** `m_tready = 0` for 20 cycles with beat 0xA5A5, `tlast = 1` pending. Required: `m_tvalid` held at 1, `m_tdata = 0xA5A5` and `m_tlast = 1` stable, `s_tready = 0`, no beat lost when `m_tready` rises.
- **Enable drop mid-stall.** `STALL_LEN_LOG2 = 8`, a stall of length ≥ 10 entered, `enable` dropped 3 cycles in. Required: state is RUN on the next edge, `s_tready = 1`, and `stall_cycles` stops at 4.
- **Reset mid-stall.** Assert `reset` for 1 cycle during a stall with the register full. Required: `m_tvalid = 0`, counters 0, `lfsr = SEED`, and the stall pattern after reset is identical to the pattern after the first reset.
- **Random scoreboard.** 10,000 beats with random `s_tvalid` and `m_tready` (50%) and `stall_thresh = 64`. Required: output sequence equals input sequence, no valid withdrawal, and `stall_cycles` equals the reference-model count.
